pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 48 ++++
 rtl/pipe_hazard_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// ============================================================================
// Module  : pipe_hazard_ctrl_if
// Purpose : Hazard-unit bundle: ID/EX hazard inputs, MEM handshake, stage
//           enables/flushes and status, shared between pipeline and hazard unit.
// Revision: 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface pipe_hazard_ctrl_if;
  logic [3:0]  id_rs_a;
  logic [3:0]  id_rs_b;
  logic        id_uses_a;
  logic        id_uses_b;
  logic [3:0]  ex_rd;
  logic        ex_we;
  logic        ex_is_load;
  logic        br_taken;
  logic        mem_req;
  logic        mem_ack;
  logic        en_pc;
  logic        en_if_id;
  logic        en_id_ex;
  logic        en_ex_mem;
  logic        en_mem_wb;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        prohib_mem;
  logic        err;
  logic [15:0] stall_cnt;
  logic [1:0]  state;

  modport master (
    output id_rs_a, id_rs_b, id_uses_a, id_uses_b, ex_rd, ex_we, ex_is_load,
           br_taken, mem_req, mem_ack,
    input  en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush_if_id,
           flush_id_ex, prohib_mem, err, stall_cnt, state
  );

  modport slave (
    input  id_rs_a, id_rs_b, id_uses_a, id_uses_b, ex_rd, ex_we, ex_is_load,
           br_taken, mem_req, mem_ack,
    output en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush_if_id,
           flush_id_ex, prohib_mem, err, stall_cnt, state
  );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module  : pipe_hazard_ctrl
// Purpose : Pipeline hazard controller: load-use stall, branch flush, memory
//           wait freeze with timeout error, saturating stall counter.
// Revision: 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_ERR     = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] stall_q, stall_d;

  logic w_hazard;
  logic w_mem_stall;
  logic w_en_pc, w_en_if_id, w_en_id_ex, w_en_ex_mem, w_en_mem_wb;
  logic w_flush_if_id, w_flush_id_ex, w_prohib_mem;

  assign w_hazard = bus.ex_is_load & bus.ex_we & (bus.ex_rd != 4'd0) &
                    ((bus.id_uses_a & (bus.id_rs_a == bus.ex_rd)) |
                     (bus.id_uses_b & (bus.id_rs_b == bus.ex_rd)));

  // A same-cycle ack completes the access, so only req without ack freezes.
  assign w_mem_stall = bus.mem_req & ~bus.mem_ack;

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    w_en_pc       = 1'b1;
    w_en_if_id    = 1'b1;
    w_en_id_ex    = 1'b1;
    w_en_ex_mem   = 1'b1;
    w_en_mem_wb   = 1'b1;
    w_flush_if_id = 1'b0;
    w_flush_id_ex = 1'b0;
    w_prohib_mem  = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (w_mem_stall) begin
          w_en_pc      = 1'b0;
          w_en_if_id   = 1'b0;
          w_en_id_ex   = 1'b0;
          w_en_ex_mem  = 1'b0;
          w_prohib_mem = 1'b1;
          state_d      = ST_MEMWAIT;
          wait_d       = 8'd1;
        end else if (bus.br_taken) begin
          w_flush_if_id = 1'b1;
          w_flush_id_ex = 1'b1;
        end else if (w_hazard) begin
          w_en_pc       = 1'b0;
          w_en_if_id    = 1'b0;
          w_flush_id_ex = 1'b1;
        end
      end

      ST_MEMWAIT: begin
        if (bus.mem_ack) begin
          state_d = ST_RUN;
          wait_d  = 8'd0;
        end else begin
          // EX is frozen here, so branch and load-use resolve after exit.
          w_en_pc      = 1'b0;
          w_en_if_id   = 1'b0;
          w_en_id_ex   = 1'b0;
          w_en_ex_mem  = 1'b0;
          w_prohib_mem = 1'b1;
          if (wait_q == WAIT_LIMIT) begin
            state_d = ST_ERR;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
      end

      ST_ERR: begin
        w_en_pc      = 1'b0;
        w_en_if_id   = 1'b0;
        w_en_id_ex   = 1'b0;
        w_en_ex_mem  = 1'b0;
        w_en_mem_wb  = 1'b0;
        w_prohib_mem = 1'b1;
      end

      default: begin
        state_d = ST_RUN;
        wait_d  = 8'd0;
      end
    endcase

    stall_d = stall_q;
    if (!w_en_pc && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      wait_q  <= 8'd0;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  // Reset forces the run/no-event view regardless of registered state.
  assign bus.en_pc       = rst | w_en_pc;
  assign bus.en_if_id    = rst | w_en_if_id;
  assign bus.en_id_ex    = rst | w_en_id_ex;
  assign bus.en_ex_mem   = rst | w_en_ex_mem;
  assign bus.en_mem_wb   = rst | w_en_mem_wb;
  assign bus.flush_if_id = ~rst & w_flush_if_id;
  assign bus.flush_id_ex = ~rst & w_flush_id_ex;
  assign bus.prohib_mem  = ~rst & w_prohib_mem;
  assign bus.err         = ~rst & (state_q == ST_ERR);
  assign bus.state       = rst ? 2'd0 : state_q;
  assign bus.stall_cnt   = rst ? 16'd0 : stall_q;

endmodule

`default_nettype wire
